// File: rtl/idct_transpose.sv
// Ping-pong transpose buffer between the row and column IDCT stages (4x4 or 8x8 blocks).
// Define IDCT_TRANSPOSE_OVF_EN to add a sticky overflow flag output (ovf).
module idct_transpose #(
    parameter int DW   = 16,
    parameter int MAXN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] din,
    input  logic                 din_valid,
    input  logic [1:0]           mode,
    output logic signed [DW-1:0] dout,
    output logic                 dout_valid,
    output logic                 dout_last,
`ifdef IDCT_TRANSPOSE_OVF_EN
    output logic                 ovf,
`endif
    output logic                 busy
);

    localparam int DEPTH = MAXN * MAXN;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST8 = AW'(63);
    localparam logic [AW-1:0] LAST4 = AW'(15);

    logic signed [DW-1:0] mem [0:2*DEPTH-1];
    logic signed [DW-1:0] rd_data;

    logic [1:0]    full;
    logic [1:0]    full_next;
    logic [1:0]    bank_is8;
    logic          wr_bank;
    logic          rd_bank;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_cnt;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic          rd_last;

    logic wr_en;
    logic wr_is8;
    logic wr_done;
    logic rd_en;
    logic rd_is8;
    logic rd_done;

    // The mode tag of a block is taken from the mode input on its first sample only.
    assign wr_en   = din_valid & ~full[wr_bank];
    assign wr_is8  = (wr_cnt == '0) ? (mode == 2'b01) : bank_is8[wr_bank];
    assign wr_done = wr_en & (wr_cnt == (wr_is8 ? LAST8 : LAST4));
    assign rd_en   = full[rd_bank];
    assign rd_is8  = bank_is8[rd_bank];
    assign rd_done = rd_en & (rd_cnt == (rd_is8 ? LAST8 : LAST4));

    assign busy = full[wr_bank] | (full[rd_bank] & (wr_cnt != '0));

    // Column-major read: index k maps to row-major address (k mod N)*N + (k div N).
    always_comb begin
        rd_addr = '0;
        if (rd_is8)
            rd_addr[5:0] = {rd_cnt[2:0], rd_cnt[5:3]};
        else
            rd_addr[3:0] = {rd_cnt[1:0], rd_cnt[3:2]};
    end

    always_comb begin
        full_next = full;
        if (wr_done)
            full_next[wr_bank] = 1'b1;
        if (rd_done)
            full_next[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wr_bank, wr_cnt}] <= din;
        if (rd_en)
            rd_data <= mem[{rd_bank, rd_addr}];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full     <= '0;
            bank_is8 <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            full     <= full_next;
            rd_valid <= rd_en;
            rd_last  <= rd_done;
            if (wr_en) begin
                if (wr_cnt == '0)
                    bank_is8[wr_bank] <= (mode == 2'b01);
                if (wr_done) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (rd_en) begin
                if (rd_done) begin
                    rd_cnt  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            dout_valid <= rd_valid;
            dout_last  <= rd_last;
            if (rd_valid)
                dout <= rd_data;
        end
    end

`ifdef IDCT_TRANSPOSE_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= 1'b0;
        else if (din_valid & full[wr_bank])
            ovf <= 1'b1;
    end
`endif

endmodule
